// File: rtl/event_recorder.sv
// Records timestamped events into a buffer and replays them on NUM_CHANNELS
// independently delayed channels, once or looping; outputs are registered (1-cycle).
module event_recorder #(
  parameter int NUM_CHANNELS = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int TIME_WIDTH   = 10,
  parameter int DEPTH        = 64,
  localparam int ENTRY_W     = TIME_WIDTH + DATA_WIDTH,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = AW + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            begin_write,
  input  logic                            stop_write,
  input  logic                            begin_read,
  input  logic                            stop_read,
  input  logic                            tick,
  input  logic [DATA_WIDTH-1:0]           write_data,
  input  logic                            write_trigger,
  input  logic                            loop,
  input  logic [NUM_CHANNELS*TIME_WIDTH-1:0] chan_delay,
  output logic [NUM_CHANNELS*ENTRY_W-1:0] read_data,
  output logic [NUM_CHANNELS-1:0]         read_trigger,
  output logic                            busy_write,
  output logic                            busy_read,
  output logic                            done,
  output logic                            overflow,
  output logic [CW-1:0]                   count
);

  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY} state_e;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_e                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [TIME_WIDTH-1:0]   rtimer_q, rtimer_d;
  logic [TIME_WIDTH:0]     ptimer_q, ptimer_d;
  logic                    loop_q, loop_d;
  logic                    done_q, done_d;
  logic [CW-1:0]           ptr_q   [NUM_CHANNELS];
  logic [CW-1:0]           ptr_d   [NUM_CHANNELS];
  logic [TIME_WIDTH-1:0]   delay_q [NUM_CHANNELS];
  logic [TIME_WIDTH-1:0]   delay_d [NUM_CHANNELS];
  logic [ENTRY_W-1:0]      rdata_q [NUM_CHANNELS];
  logic [ENTRY_W-1:0]      rdata_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] trig_q, trig_d;
  logic [ENTRY_W-1:0]      rd_entry [NUM_CHANNELS];
  logic [ENTRY_W-1:0]      mem_q   [DEPTH];
  logic                    mem_we;
  logic [ENTRY_W-1:0]      mem_wdata;
  logic                    start_rec, all_done, emit_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rtimer_q   <= '0;
      ptimer_q   <= '0;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
      trig_q     <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        ptr_q[c]   <= '0;
        delay_q[c] <= '0;
        rdata_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rtimer_q   <= rtimer_d;
      ptimer_q   <= ptimer_d;
      loop_q     <= loop_d;
      done_q     <= done_d;
      trig_q     <= trig_d;
      ptr_q      <= ptr_d;
      delay_q    <= delay_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && mem_we) mem_q[count_q[AW-1:0]] <= mem_wdata;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rtimer_d   = rtimer_q;
    ptimer_d   = ptimer_q;
    loop_d     = loop_q;
    done_d     = 1'b0;
    trig_d     = '0;
    ptr_d      = ptr_q;
    delay_d    = delay_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    mem_wdata  = {rtimer_q, write_data};
    start_rec  = 1'b0;
    emit_en    = 1'b0;
    all_done   = 1'b1;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rd_entry[c] = mem_q[ptr_q[c][AW-1:0]];
      if (ptr_q[c] < count_q) all_done = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (begin_write) begin
          start_rec = 1'b1;
        end else if (begin_read) begin
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_PLAY;
            ptimer_d = '0;
            loop_d   = loop;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
              ptr_d[c]   = '0;
              delay_d[c] = chan_delay[c*TIME_WIDTH +: TIME_WIDTH];
            end
          end
        end
      end
      S_RECORD: begin
        if (stop_write) begin
          state_d = S_IDLE;
        end else if (begin_write) begin
          start_rec = 1'b1;
        end else if (tick) begin
          if (&rtimer_q) state_d = S_IDLE;
          else           rtimer_d = rtimer_q + 1'b1;
        end
        // A restart discards the coincident event; a stop still keeps it.
        if (write_trigger && (stop_write || !begin_write)) begin
          if (count_q == FULL) begin
            overflow_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (stop_read) begin
          state_d = S_IDLE;
        end else if (begin_write) begin
          start_rec = 1'b1;
        end else if (all_done) begin
          if (loop_q) begin
            ptimer_d = '0;
            for (int c = 0; c < NUM_CHANNELS; c++) ptr_d[c] = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          emit_en = 1'b1;
          if (tick && !(&ptimer_q)) ptimer_d = ptimer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_rec) begin
      state_d    = S_RECORD;
      count_d    = '0;
      overflow_d = 1'b0;
      rtimer_d   = '0;
    end

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (emit_en && (ptr_q[c] < count_q) &&
          ({1'b0, rd_entry[c][ENTRY_W-1:DATA_WIDTH]} + {1'b0, delay_q[c]} <= ptimer_q)) begin
        trig_d[c]  = 1'b1;
        rdata_d[c] = rd_entry[c];
        ptr_d[c]   = ptr_q[c] + 1'b1;
      end
    end
  end

  always_comb begin
    busy_write   = (state_q == S_RECORD);
    busy_read    = (state_q == S_PLAY);
    done         = done_q;
    overflow     = overflow_q;
    count        = count_q;
    read_trigger = trig_q;
    read_data    = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) read_data[c*ENTRY_W +: ENTRY_W] = rdata_q[c];
  end

endmodule

// File: tb/tb_event_recorder.sv
// Directed scenarios followed by random traffic, all checked cycle by cycle
// against a queue-based reference model of record/playback behaviour.
module tb_event_recorder;
  localparam int NC = 2;
  localparam int DW = 8;
  localparam int TW = 4;
  localparam int DEPTH = 4;
  localparam int EW = TW + DW;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TMAX = (1 << TW) - 1;
  localparam int PMAX = (1 << (TW + 1)) - 1;

  logic clk = 1'b0;
  logic rst_n, bw, sw, br, sr, tk, ww, lp;
  logic [DW-1:0] wd;
  logic [NC*TW-1:0] cdly;
  logic [NC*EW-1:0] read_data;
  logic [NC-1:0] read_trigger;
  logic busy_write, busy_read, done, overflow;
  logic [CW-1:0] count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  event_recorder #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .TIME_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .begin_write(bw), .stop_write(sw), .begin_read(br),
    .stop_read(sr), .tick(tk), .write_data(wd), .write_trigger(ww), .loop(lp),
    .chan_delay(cdly), .read_data(read_data), .read_trigger(read_trigger),
    .busy_write(busy_write), .busy_read(busy_read), .done(done), .overflow(overflow),
    .count(count)
  );

  // Reference model: mode 0 idle, 1 record, 2 play; recording held as queues.
  int m_mode, m_rtimer, m_ptimer, m_loop, m_ovf, m_done;
  int m_ts[$];
  int m_dat[$];
  int m_ptr[NC], m_dly[NC], m_trig[NC], m_rts[NC], m_rdat[NC];

  // Observations gathered for the directed scenarios.
  int ntrig[NC], last_rd[NC], ndone;
  int cyc0[$];
  int dat0[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit restart, all_done;
    int p;
    m_done = 0;
    for (int c = 0; c < NC; c++) m_trig[c] = 0;
    if (!rst_n) begin
      m_mode = 0; m_ts.delete(); m_dat.delete(); m_ovf = 0;
      m_rtimer = 0; m_ptimer = 0; m_loop = 0;
      for (int c = 0; c < NC; c++) begin
        m_ptr[c] = 0; m_dly[c] = 0; m_rts[c] = 0; m_rdat[c] = 0;
      end
      return;
    end
    restart = 0;
    case (m_mode)
      0: begin
        if (bw) restart = 1;
        else if (br) begin
          if (m_ts.size() == 0) m_done = 1;
          else begin
            m_mode = 2; m_ptimer = 0; m_loop = lp;
            for (int c = 0; c < NC; c++) begin
              m_ptr[c] = 0;
              m_dly[c] = int'(cdly[c*TW +: TW]);
            end
          end
        end
      end
      1: begin
        if (ww && (sw || !bw)) begin
          if (m_ts.size() == DEPTH) m_ovf = 1;
          else begin m_ts.push_back(m_rtimer); m_dat.push_back(int'(wd)); end
        end
        if (sw) m_mode = 0;
        else if (bw) restart = 1;
        else if (tk) begin
          if (m_rtimer == TMAX) m_mode = 0;
          else m_rtimer++;
        end
      end
      default: begin
        if (sr) m_mode = 0;
        else if (bw) restart = 1;
        else begin
          all_done = 1;
          for (int c = 0; c < NC; c++) if (m_ptr[c] < m_ts.size()) all_done = 0;
          if (all_done) begin
            if (m_loop != 0) begin
              m_ptimer = 0;
              for (int c = 0; c < NC; c++) m_ptr[c] = 0;
            end else begin
              m_mode = 0; m_done = 1;
            end
          end else begin
            for (int c = 0; c < NC; c++) begin
              p = m_ptr[c];
              if (p < m_ts.size() && m_ts[p] + m_dly[c] <= m_ptimer) begin
                m_trig[c] = 1; m_rts[c] = m_ts[p]; m_rdat[c] = m_dat[p]; m_ptr[c]++;
              end
            end
            if (tk && m_ptimer < PMAX) m_ptimer++;
          end
        end
      end
    endcase
    if (restart) begin
      m_mode = 1; m_ts.delete(); m_dat.delete(); m_ovf = 0; m_rtimer = 0;
    end
  endtask

  // One clock: predict, clock, compare every output, record observations, clear pulses.
  task automatic step();
    logic [NC-1:0] et;
    logic [NC*EW-1:0] ed;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < NC; c++) begin
      et[c] = m_trig[c][0];
      ed[c*EW +: EW] = {TW'(m_rts[c]), DW'(m_rdat[c])};
    end
    chk("count", 64'(count), 64'(m_ts.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("done", 64'(done), 64'(m_done));
    chk("busy_write", 64'(busy_write), 64'(m_mode == 1));
    chk("busy_read", 64'(busy_read), 64'(m_mode == 2));
    chk("read_trigger", 64'(read_trigger), 64'(et));
    chk("read_data", 64'(read_data), 64'(ed));
    for (int c = 0; c < NC; c++) begin
      if (read_trigger[c] === 1'b1) begin
        ntrig[c]++;
        last_rd[c] = int'(read_data[c*EW +: EW]);
        if (c == 0) begin cyc0.push_back(cyc); dat0.push_back(int'(read_data[DW-1:0])); end
      end
    end
    if (done === 1'b1) ndone++;
    bw = 0; sw = 0; br = 0; sr = 0; tk = 0; ww = 0;
  endtask

  task automatic clr_obs();
    for (int c = 0; c < NC; c++) begin ntrig[c] = 0; last_rd[c] = 0; end
    ndone = 0; cyc0.delete(); dat0.delete();
  endtask

  task automatic wr(input logic [DW-1:0] d);
    ww = 1; wd = d; step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int exp0[6];
    int exp1[6];
    int saved;
    exp0 = '{1, 1, 1, 2, 2, 2};
    exp1 = '{0, 0, 1, 1, 1, 2};
    rst_n = 0; bw = 0; sw = 0; br = 0; sr = 0; tk = 0; ww = 0; lp = 0; wd = '0; cdly = '0;
    clr_obs();
    idle(2);
    rst_n = 1;
    idle(1);

    // Two events at timer 0 and 3, played on delays {0,2}.
    bw = 1; step();
    wr(8'h11);
    for (int i = 0; i < 3; i++) begin tk = 1; step(); end
    wr(8'h22);
    sw = 1; step();
    chk("rec2_count", 64'(count), 64'd2);
    clr_obs();
    cdly = {4'd2, 4'd0}; lp = 0;
    br = 1; step();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin tk = 1; step(); end
      idle(3);
      chk($sformatf("ch0_n_t%0d", k), 64'(ntrig[0]), 64'(exp0[k]));
      chk($sformatf("ch1_n_t%0d", k), 64'(ntrig[1]), 64'(exp1[k]));
    end
    chk("two_ev_done_n", 64'(ndone), 64'd1);
    chk("ch1_last", 64'(last_rd[1]), 64'h322);
    chk("ch0_last", 64'(last_rd[0]), 64'h322);

    // Overflow: six writes into four entries.
    bw = 1; step();
    for (int i = 1; i <= 6; i++) wr(DW'(i));
    sw = 1; step();
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    clr_obs();
    cdly = '0; br = 1; step();
    idle(8);
    chk("ovf_play_n", 64'(ntrig[0]), 64'd4);
    chk("ovf_play_last", 64'(last_rd[0]), 64'h004);
    chk("ovf_done_n", 64'(ndone), 64'd1);

    // Three coincident timestamps emit on consecutive cycles in order.
    bw = 1; step();
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    sw = 1; step();
    clr_obs();
    br = 1; step();
    idle(6);
    chk("same_ts_n", 64'(cyc0.size()), 64'd3);
    if (cyc0.size() >= 3) begin
      chk("same_ts_gap1", 64'(cyc0[1] - cyc0[0]), 64'd1);
      chk("same_ts_gap2", 64'(cyc0[2] - cyc0[1]), 64'd1);
      chk("same_ts_d0", 64'(dat0[0]), 64'hA1);
      chk("same_ts_d2", 64'(dat0[2]), 64'hA3);
    end

    // Looping playback, then stop_read.
    bw = 1; step();
    wr(8'h55); tk = 1; step(); wr(8'h66);
    sw = 1; step();
    clr_obs();
    lp = 1; br = 1; step();
    for (int i = 0; i < 20; i++) begin tk = 1; step(); end
    chk("loop_repeats", 64'(ntrig[0] > 4), 64'd1);
    chk("loop_no_done", 64'(ndone), 64'd0);
    sr = 1; step();
    saved = ntrig[0];
    idle(4);
    chk("stop_read_quiet", 64'(ntrig[0]), 64'(saved));
    chk("stop_read_idle", 64'(busy_read), 64'd0);

    // Reset mid-play, then begin_read finds nothing stored.
    br = 1; step();
    idle(3);
    rst_n = 0; step();
    rst_n = 1;
    clr_obs();
    lp = 0; br = 1; step();
    chk("post_rst_done", 64'(done), 64'd1);
    idle(3);
    chk("post_rst_trig", 64'(ntrig[0] + ntrig[1]), 64'd0);
    chk("post_rst_idle", 64'(busy_read), 64'd0);

    // Command priority.
    bw = 1; br = 1; step();
    chk("bw_over_br", 64'(busy_write), 64'd1);
    wr(8'h77);
    bw = 1; sw = 1; step();
    chk("sw_over_bw", 64'(busy_write), 64'd0);
    chk("sw_keeps_count", 64'(count), 64'd1);

    // Record timer saturation: the tick after reaching all-ones ends recording.
    bw = 1; step();
    for (int i = 0; i < TMAX; i++) begin tk = 1; step(); end
    chk("sat_still_rec", 64'(busy_write), 64'd1);
    wr(8'h99);
    tk = 1; step();
    chk("sat_forced_idle", 64'(busy_write), 64'd0);
    chk("sat_count", 64'(count), 64'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(299) != 0);
      bw = ($urandom_range(39) == 0);
      sw = ($urandom_range(59) == 0);
      br = ($urandom_range(24) == 0);
      sr = ($urandom_range(79) == 0);
      tk = ($urandom_range(2) == 0);
      ww = ($urandom_range(2) == 0);
      wd = DW'($urandom);
      lp = ($urandom_range(3) == 0);
      cdly = (NC*TW)'($urandom);
      step();
    end
    rst_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/event_recorder.md
EVENT_RECORDER -- requirements
Module: event_recorder

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2, number of independent playback channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, event payload width.
REQ-003 SHALL have parameter TIME_WIDTH, default 10, timestamp width in ticks; ENTRY_W = TIME_WIDTH+DATA_WIDTH (default 18).
REQ-004 SHALL have parameter DEPTH, default 64, event storage entries, power of two; CW = log2(DEPTH)+1.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have ports begin_write, stop_write, begin_read, stop_read  input  1 each  single-cycle commands.
REQ-008 SHALL have port tick  input  1  time-base strobe, one cycle wide.
REQ-009 SHALL have ports write_data  input  DATA_WIDTH, write_trigger  input  1  event to record.
REQ-010 SHALL have port loop  input  1  sampled at begin_read; 1 = repeat playback.
REQ-011 SHALL have port chan_delay  input  NUM_CHANNELS*TIME_WIDTH  per-channel playback offset in ticks, slice c = channel c, sampled at begin_read.
REQ-012 SHALL have ports read_data  output  NUM_CHANNELS*ENTRY_W {timestamp,data} per channel, read_trigger  output  NUM_CHANNELS  one-cycle valid per channel.
REQ-013 SHALL have ports busy_write, busy_read, done, overflow  output  1 each; count  output  CW  stored entries.

Function
REQ-014 SHALL implement states IDLE, RECORD, PLAY; exactly one active.
REQ-015 Command priority per cycle SHALL be stop_write/stop_read > begin_write > begin_read; a stop applies only to its own state.
REQ-016 begin_write in any state SHALL enter RECORD next cycle: count=0, overflow=0, record timer=0; aborts PLAY without done.
REQ-017 In RECORD, tick SHALL increment the record timer; at all-ones the timer saturates and the next tick forces IDLE.
REQ-018 In RECORD, write_trigger SHALL store {timer,write_data} at index count and increment count; with simultaneous tick the pre-increment timer value is stored.
REQ-019 write_trigger with count==DEPTH SHALL drop the event and set overflow (sticky until next begin_write or reset).
REQ-020 write_trigger outside RECORD SHALL be ignored.
REQ-021 stop_write SHALL return to IDLE next cycle; stored entries and count retained.
REQ-022 begin_read from IDLE SHALL enter PLAY: play timer=0, every channel pointer=0, loop and chan_delay latched; with count==0 it SHALL instead pulse done next cycle and stay IDLE.
REQ-023 In PLAY, tick SHALL increment the play timer (TIME_WIDTH+1 bits, no wrap within one pass).
REQ-024 Channel c SHALL emit entry p when p<count and entry timestamp + delay_c <= play timer: read_data slice c = entry, read_trigger[c]=1 for one cycle, pointer advances.
REQ-025 Each channel SHALL emit at most one entry per cycle; coincident timestamps emit on consecutive cycles in stored order.
REQ-026 Channels SHALL operate independently; simultaneous triggers on several channels allowed.
REQ-027 read_data slice SHALL hold last emitted value between triggers.
REQ-028 When all pointers reach count: loop=0 -> done pulses one cycle and IDLE; loop=1 -> play timer and pointers reset to 0 next cycle, no done, PLAY continues.
REQ-029 stop_read SHALL return PLAY to IDLE next cycle, no done, no further triggers.
REQ-030 begin_read while RECORD or PLAY SHALL be ignored.
REQ-031 busy_write=1 exactly in RECORD; busy_read=1 exactly in PLAY.

Reset
REQ-032 reset=0 at a clock edge SHALL force IDLE, count=0, overflow=0, done=0, read_trigger=0, read_data=0, timers and pointers 0, from any state, mid-operation included.
REQ-033 Commands sampled in a reset cycle SHALL be ignored.

Verification
REQ-034 Record 0x11 at timer 0, 0x22 at timer 3, stop; play delays {0,2} -> ch0 triggers at timer 0 and 3, ch1 at 2 and 5, data {0,0x11},{3,0x22}, then done once.
REQ-035 DEPTH=4, 6 write_triggers -> count=4, overflow=1, entries 5-6 absent on playback.
REQ-036 Three writes same timer value, delay 0 -> three triggers on three consecutive cycles, stored order.
REQ-037 loop=1, two entries -> repeated passes, no done; stop_read -> IDLE, triggers cease next cycle.
REQ-038 reset=0 mid-PLAY then begin_read -> done pulse next cycle (count=0), no triggers.
REQ-039 begin_write and begin_read same cycle -> RECORD; stop_write with begin_write same cycle -> IDLE.
